// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART transmit constants and FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_tx_buffered_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} uart_tx_state_t;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Generic synchronous FIFO with registered storage and an occupancy counter.
// Latency: a pushed entry is visible on rdata the cycle after the push edge.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
//
// Ports: clk/rst (sync, active-high); push/wdata write side; pop/rdata read side
// (rdata is the current head, combinational); full, empty, count (occupancy).
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2:0]    r_count;
    logic                   w_push;
    logic                   w_pop;

    assign full   = (r_count == FULL_CNT);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO-queued bytes serialised on txd, LSB first.
// Latency: push into empty FIFO while idle at edge N -> start bit on txd after edge N+2.
// Backpressure: wready = FIFO not full; wvalid while !wready is dropped.
//
// Ports: clk, rst (sync, active-high); wdata/wvalid/wready push port; txd serial
// line (registered, idle high); busy; count (FIFO occupancy, excludes shifter);
// tx_done (one-cycle pulse aligned with the last cycle of each stop bit on txd).
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int FIFO_DEPTH_LOG2  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 wdata,
    input  logic                       wvalid,
    output logic                       wready,
    output logic                       txd,
    output logic                       busy,
    output logic [FIFO_DEPTH_LOG2:0]   count,
    output logic                       tx_done
);

    localparam int BAUD_W = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t              r_state;
    logic [BAUD_W-1:0]           r_baud_cnt;
    logic [2:0]                  r_bit_idx;
    logic [UART_DATA_BITS-1:0]   r_shift;
    logic                        r_txd;
    logic                        r_tx_done;

    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [7:0]                  w_fifo_rdata;
    logic [FIFO_DEPTH_LOG2:0]    w_fifo_count;
    logic                        w_bit_end;
    logic                        w_pop;

    assign w_bit_end = (r_baud_cnt == BAUD_LAST);
    // Pop when idle, or at the very end of a stop bit so frames run back-to-back.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == TX_IDLE) || ((r_state == TX_STOP) && w_bit_end));

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wvalid),
        .wdata (wdata),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // txd and tx_done are registered from the current state, so the line
    // trails the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= TX_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    r_txd      <= 1'b1;
                    r_baud_cnt <= '0;
                    if (!w_fifo_empty) begin
                        r_shift <= w_fifo_rdata;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    r_txd <= 1'b0;
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= TX_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    r_txd <= r_shift[0];
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_shift    <= r_shift >> 1;
                        r_bit_idx  <= r_bit_idx + 1'b1;
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= TX_STOP;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    r_txd <= 1'b1;
                    if (w_bit_end) begin
                        r_tx_done  <= 1'b1;
                        r_baud_cnt <= '0;
                        if (!w_fifo_empty) begin
                            r_shift <= w_fifo_rdata;
                            r_state <= TX_START;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign wready  = !w_fifo_full;
    assign txd     = r_txd;
    assign tx_done = r_tx_done;
    assign count   = w_fifo_count;
    assign busy    = (r_state != TX_IDLE) || (w_fifo_count != '0);

endmodule
